ps2_host_tx: RTL

- Host-to-device PS/2 transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable.
- Counterpart to the existing PS/2 receive path; shares the same ps2clk/ps2data lines through open-drain enables.
- Performs the full request-to-send sequence: inhibit, start, 8 data bits LSB first, odd parity, stop, then checks the device acknowledge.
- Reports completion or error to the command sequencer through a valid/ready handshake.

---
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8N-odd frame, device ack check.
// Optional build macro PS2_HOST_TX_RETRY_EN: a failed frame is retried once before error pulses.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, FAIL
    } state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       bit_idx, bit_idx_nxt;
    logic [9:0]       shreg, shreg_nxt;
    logic             clk_oe_nxt, data_oe_nxt;
    logic             data_sync_p0, data_sync_p1;
    logic [7:0]       clk_sr;
    logic             fall_edge, line_idle, timeout, fail_req;
`ifdef PS2_HOST_TX_RETRY_EN
    logic             retried, retried_nxt;
`endif

    // Same falling-edge filter as the receive path: four high samples followed by four low ones.
    assign fall_edge = (clk_sr[7:4] == 4'hF) && (clk_sr[3:0] == 4'h0);
    assign line_idle = data_sync_p1 && (clk_sr[3:0] == 4'hF);
    assign timeout   = (cnt == TIMEOUT_LAST);

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign error    = (state == FAIL);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        clk_oe_nxt  = ps2clk_oe;
        data_oe_nxt = ps2data_oe;
        fail_req    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retried_nxt = retried;
`endif
        case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (tx_valid) begin
                    state_nxt  = INHIBIT;
                    shreg_nxt  = {1'b1, ~^tx_data, tx_data};
                    cnt_nxt    = '0;
                    clk_oe_nxt = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                    retried_nxt = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                clk_oe_nxt  = 1'b1;
                data_oe_nxt = 1'b0;
                if (cnt == INHIBIT_LAST) begin
                    state_nxt   = RTS;
                    cnt_nxt     = '0;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RTS: begin
                cnt_nxt     = cnt + 1'b1;
                bit_idx_nxt = '0;
                state_nxt   = SEND;
            end
            SEND: begin
                cnt_nxt = cnt + 1'b1;
                if (timeout) begin
                    fail_req = 1'b1;
                end else if (fall_edge) begin
                    data_oe_nxt = ~shreg[bit_idx];
                    if (bit_idx == 4'd9) state_nxt = ACK;
                    else bit_idx_nxt = bit_idx + 1'b1;
                end
            end
            ACK: begin
                data_oe_nxt = 1'b0;
                cnt_nxt     = cnt + 1'b1;
                if (timeout) begin
                    fail_req = 1'b1;
                end else if (fall_edge) begin
                    if (data_sync_p1) fail_req = 1'b1;
                    else state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_nxt = cnt + 1'b1;
                if (timeout) fail_req = 1'b1;
                else if (line_idle) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            FAIL: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (fail_req) begin
            state_nxt   = FAIL;
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            // One automatic retry with the same latched byte.
            if (!retried) begin
                state_nxt   = INHIBIT;
                cnt_nxt     = '0;
                clk_oe_nxt  = 1'b1;
                retried_nxt = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            ps2clk_oe    <= 1'b0;
            ps2data_oe   <= 1'b0;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
            clk_sr       <= 8'hFF;
`ifdef PS2_HOST_TX_RETRY_EN
            retried      <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            ps2clk_oe    <= clk_oe_nxt;
            ps2data_oe   <= data_oe_nxt;
            data_sync_p0 <= ps2data;
            data_sync_p1 <= data_sync_p0;
            clk_sr       <= {clk_sr[6:0], ps2clk};
`ifdef PS2_HOST_TX_RETRY_EN
            retried      <= retried_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

endmodule
